fp_add_seq_ctrl: RTL and testbench

//   Sequencer for the half-precision FP adder datapath: serial operand load -> adder -> output register -> serial drain.

---
 rtl/fp_add_seq_ctrl_pkg.sv | 17 +
 rtl/fp_add_bit_counter.sv | 30 +++
 rtl/fp_add_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_fp_add_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_seq_ctrl_pkg.sv
// Shared definitions for the FP adder sequencer: state encodings and default sizing.
package fp_add_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ADD      = 3'd2,
        ST_WAIT_ADD = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

    localparam int unsigned FP_WIDTH_DEF       = 16;
    localparam int unsigned FP_ADD_TIMEOUT_DEF = 32;
    localparam int unsigned FP_CNT_W_DEF       = 6;

endpackage

// File: rtl/fp_add_bit_counter.sv
// Up-counter shared by the LOAD, WAIT_ADD-timeout and DRAIN phases; done flags cnt == term_in.
module fp_add_bit_counter
    import fp_add_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = FP_CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term_in,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over enable so each phase starts counting from zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign done = (r_cnt == term_in);

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Sequencer for the serial half-precision FP adder: load -> add -> write -> drain.
// Optional WAIT_ADD abort timer enabled by defining FP_ADD_TIMEOUT_EN.
module fp_add_seq_ctrl
    import fp_add_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = FP_WIDTH_DEF,
    parameter int unsigned ADD_TIMEOUT = FP_ADD_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = FP_CNT_W_DEF
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic op_valid_in,
    output logic op_ready,
    output logic in_shift_en,
    output logic add_start,
    input  logic add_done_in,
    output logic out_wr,
    input  logic output_rdy_in,
    input  logic output_read_in,
    output logic out_read,
    output logic busy,
    output logic timeout_err
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_cnt_done;
    logic [CNT_W-1:0]   w_cnt_term;
`ifdef FP_ADD_TIMEOUT_EN
    logic               w_timeout;
    logic               r_timeout_err;
`endif

    // output_rdy_in is informational only: an empty output register does not shorten DRAIN.
    logic w_unused;
    assign w_unused = &{1'b0, output_rdy_in, (ADD_TIMEOUT != 0)};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_en     = 1'b0;
        w_cnt_term   = CNT_W'(WIDTH - 1);
`ifdef FP_ADD_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (op_valid_in) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_cnt_en = 1'b1;
                if (w_cnt_done) w_state_next = ST_ADD;
            end
            ST_ADD: begin
                w_state_next = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
`ifdef FP_ADD_TIMEOUT_EN
                w_cnt_en   = 1'b1;
                w_cnt_term = CNT_W'(ADD_TIMEOUT - 1);
                // A result arriving on the expiry cycle still completes the op.
                if (add_done_in) begin
                    w_state_next = ST_WRITE;
                end else if (w_cnt_done) begin
                    w_state_next = ST_IDLE;
                    w_timeout    = 1'b1;
                end
`else
                if (add_done_in) w_state_next = ST_WRITE;
`endif
            end
            ST_WRITE: begin
                w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_cnt_en = output_read_in;
                if (output_read_in && w_cnt_done) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_cnt_clr = (w_state_next != r_state);

    fp_add_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr      (w_cnt_clr),
        .en       (w_cnt_en),
        .term_in  (w_cnt_term),
        .done     (w_cnt_done)
    );

`ifdef FP_ADD_TIMEOUT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_timeout_err <= 1'b0;
        end else if (r_state == ST_IDLE && op_valid_in) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign op_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign in_shift_en = (r_state == ST_LOAD);
    assign add_start   = (r_state == ST_ADD);
    assign out_wr      = (r_state == ST_WRITE);
    assign out_read    = output_read_in & (r_state == ST_DRAIN);

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed bench for fp_add_seq_ctrl; timeout cases run when FP_ADD_TIMEOUT_EN is defined.
module tb_fp_add_seq_ctrl;

    logic clk_in;
    logic rst_n_in;
    logic op_valid_in;
    logic op_ready;
    logic in_shift_en;
    logic add_start;
    logic add_done_in;
    logic out_wr;
    logic output_rdy_in;
    logic output_read_in;
    logic out_read;
    logic busy;
    logic timeout_err;

    int n_vec;
    int n_err;

    fp_add_seq_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .op_valid_in    (op_valid_in),
        .op_ready       (op_ready),
        .in_shift_en    (in_shift_en),
        .add_start      (add_start),
        .add_done_in    (add_done_in),
        .out_wr         (out_wr),
        .output_rdy_in  (output_rdy_in),
        .output_read_in (output_read_in),
        .out_read       (out_read),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Accept an op from IDLE; returns during the ADD cycle (17th after accept).
    task automatic do_load();
        op_valid_in = 1'b1;
        tick();
        op_valid_in = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            op_valid_in    = c[0];
            output_read_in = c[1];
            add_done_in    = c[2];
            #1;
            chk("load_shift", in_shift_en, (c <= 16));
            chk("load_start", add_start, (c == 17));
            chk("load_rd", out_read, 0);
            chk("load_rdy", op_ready, 0);
            if (c < 17) tick();
        end
        op_valid_in    = 1'b0;
        output_read_in = 1'b0;
        add_done_in    = 1'b0;
    endtask

    // From ADD: add_done_in rises in the n-th WAIT_ADD cycle; returns in the WRITE cycle.
    task automatic do_wait(input int n);
        for (int w = 1; w <= n; w++) begin
            tick();
            add_done_in    = (w == n);
            output_read_in = w[0];
            #1;
            chk("wait_busy", busy, 1);
            chk("wait_rdy", op_ready, 0);
            chk("wait_wr", out_wr, 0);
            chk("wait_rd", out_read, 0);
        end
        tick();
        add_done_in    = 1'b0;
        output_read_in = 1'b0;
        chk("write_wr", out_wr, 1);
        chk("write_busy", busy, 1);
        tick();
        chk("drain_wr_once", out_wr, 0);
    endtask

    // In DRAIN: read high n_hi1, low n_lo, high n_hi2 (n_hi1 + n_hi2 == 16).
    task automatic do_drain(input int n_hi1, input int n_lo, input int n_hi2);
        int total;
        logic rd;
        total = n_hi1 + n_lo + n_hi2;
        for (int j = 0; j < total; j++) begin
            rd = (j < n_hi1) || (j >= n_hi1 + n_lo);
            output_read_in = rd;
            #1;
            chk("drain_rd", out_read, rd);
            chk("drain_busy", busy, 1);
            tick();
        end
        chk("drain_end_rdy", op_ready, 1);
        chk("drain_end_busy", busy, 0);
        chk("drain_end_rd", out_read, 0);
        output_read_in = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n_in       = 1'b0;
        op_valid_in    = 1'b0;
        add_done_in    = 1'b0;
        output_rdy_in  = 1'b1;
        output_read_in = 1'b0;

        repeat (2) tick();
        chk("rst_rdy", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_shift", in_shift_en, 0);
        chk("rst_start", add_start, 0);
        chk("rst_wr", out_wr, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n_in = 1'b1;
        tick();
        chk("idle_rdy", op_ready, 1);
        $display("reset checked, vectors=%0d", n_vec);

        do_load();
        do_wait(3);
        output_rdy_in = 1'b0;
        do_drain(8, 5, 8);
        output_rdy_in = 1'b1;
        $display("op 1 (paused drain, empty output reg) done, vectors=%0d", n_vec);

        output_read_in = 1'b1;
        add_done_in    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_ign_rdy", op_ready, 1);
            chk("idle_ign_rd", out_read, 0);
            chk("idle_ign_busy", busy, 0);
        end
        output_read_in = 1'b0;
        add_done_in    = 1'b0;
        $display("idle ignore checked, vectors=%0d", n_vec);

        op_valid_in = 1'b1;
        tick();
        op_valid_in = 1'b0;
        repeat (6) tick();
        chk("mid_load_shift", in_shift_en, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rst_load_shift", in_shift_en, 0);
        chk("rst_load_rdy", op_ready, 1);
        chk("rst_load_busy", busy, 0);
        tick();
        rst_n_in = 1'b1;
        tick();
        $display("reset mid-LOAD checked, vectors=%0d", n_vec);

        do_load();
        do_wait(1);
        output_read_in = 1'b1;
        repeat (5) tick();
        chk("mid_drain_rd", out_read, 1);
        rst_n_in = 1'b0;
        #1;
        chk("rst_drain_rd", out_read, 0);
        chk("rst_drain_busy", busy, 0);
        chk("rst_drain_rdy", op_ready, 1);
        chk("rst_drain_wr", out_wr, 0);
        tick();
        rst_n_in       = 1'b1;
        output_read_in = 1'b0;
        tick();
        $display("reset mid-DRAIN checked, vectors=%0d", n_vec);

        do_load();
        do_wait(2);
        do_drain(16, 0, 0);
        $display("clean op after reset done, vectors=%0d", n_vec);

`ifdef FP_ADD_TIMEOUT_EN
        do_load();
        for (int w = 1; w <= 32; w++) begin
            tick();
            chk("to_wait_busy", busy, 1);
            chk("to_wait_terr", timeout_err, 0);
        end
        tick();
        chk("to_abort_terr", timeout_err, 1);
        chk("to_abort_rdy", op_ready, 1);
        chk("to_abort_busy", busy, 0);
        tick();
        chk("to_sticky", timeout_err, 1);
        do_load();
        chk("to_cleared", timeout_err, 0);
        do_wait(32);
        chk("to_edge_terr", timeout_err, 0);
        do_drain(16, 0, 0);
        chk("to_edge_final", timeout_err, 0);
        $display("timeout cases done, vectors=%0d", n_vec);
`else
        do_load();
        for (int w = 1; w <= 40; w++) begin
            tick();
            chk("long_wait_busy", busy, 1);
            chk("long_wait_terr", timeout_err, 0);
        end
        do_wait(1);
        do_drain(16, 0, 0);
        $display("long wait without timeout done, vectors=%0d", n_vec);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
